// File: rtl/gpu_mem_arbiter.sv
// Round-robin merge of several 8-bit Avalon-MM controller masters onto one
// downstream master, with a single transfer outstanding at a time.
module gpu_mem_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_PORTS*ADDR_W-1:0]   s_address,
    input  logic [NUM_PORTS*DATA_W-1:0]   s_writedata,
    input  logic [NUM_PORTS-1:0]          s_write,
    input  logic [NUM_PORTS-1:0]          s_read,
    output logic [NUM_PORTS-1:0]          s_waitrequest,
    output logic [NUM_PORTS*DATA_W-1:0]   s_readdata,
    output logic [NUM_PORTS-1:0]          s_readdatavalid,
    output logic [ADDR_W-1:0]             m_address,
    output logic [DATA_W-1:0]             m_writedata,
    output logic                          m_write,
    output logic                          m_read,
    input  logic                          m_waitrequest,
    input  logic [DATA_W-1:0]             m_readdata,
    input  logic                          m_readdatavalid
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] last_q, last_d;

    logic [NUM_PORTS-1:0] req;
    logic [ADDR_W-1:0]    g_addr;
    logic [DATA_W-1:0]    g_wdata;
    logic                 g_rd;
    logic                 g_wr;
    logic                 found;
    logic [PW-1:0]        pick;

    assign req     = s_read | s_write;
    assign g_addr  = s_address[int'(grant_q)*ADDR_W +: ADDR_W];
    assign g_wdata = s_writedata[int'(grant_q)*DATA_W +: DATA_W];
    assign g_rd    = s_read[grant_q];
    assign g_wr    = s_write[grant_q] & ~s_read[grant_q];

    // Search starts just after the last winner so every requester rotates in.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!found && req[(int'(last_q) + i) % NUM_PORTS]) begin
                found = 1'b1;
                pick  = PW'((int'(last_q) + i) % NUM_PORTS);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_d          = last_q;
        s_waitrequest   = '1;
        s_readdatavalid = '0;
        s_readdata      = '0;
        m_address       = '0;
        m_writedata     = '0;
        m_write         = 1'b0;
        m_read          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    last_d  = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                m_address   = g_addr;
                m_writedata = g_wdata;
                m_read      = g_rd;
                m_write     = g_wr;
                if (!req[grant_q]) begin
                    state_d = IDLE;
                end else if (!m_waitrequest) begin
                    if (g_rd) begin
                        // Zero-latency slave: finish the read right here.
                        if (m_readdatavalid) begin
                            s_waitrequest[grant_q]   = 1'b0;
                            s_readdatavalid[grant_q] = 1'b1;
                            s_readdata[int'(grant_q)*DATA_W +: DATA_W] = m_readdata;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_RD;
                        end
                    end else begin
                        s_waitrequest[grant_q] = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_RD: begin
                if (m_readdatavalid) begin
                    s_waitrequest[grant_q]   = 1'b0;
                    s_readdatavalid[grant_q] = 1'b1;
                    s_readdata[int'(grant_q)*DATA_W +: DATA_W] = m_readdata;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= PW'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed bench for gpu_mem_arbiter: four controller ports against a
// hand-driven downstream slave.
module tb_gpu_mem_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 8;

    logic              clock;
    logic              reset;
    logic [NP*AW-1:0]  s_address;
    logic [NP*DW-1:0]  s_writedata;
    logic [NP-1:0]     s_write;
    logic [NP-1:0]     s_read;
    logic [NP-1:0]     s_waitrequest;
    logic [NP*DW-1:0]  s_readdata;
    logic [NP-1:0]     s_readdatavalid;
    logic [AW-1:0]     m_address;
    logic [DW-1:0]     m_writedata;
    logic              m_write;
    logic              m_read;
    logic              m_waitrequest;
    logic [DW-1:0]     m_readdata;
    logic              m_readdatavalid;

    int checks;
    int failures;

    gpu_mem_arbiter #(
        .NUM_PORTS(NP),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .s_address      (s_address),
        .s_writedata    (s_writedata),
        .s_write        (s_write),
        .s_read         (s_read),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .m_address      (m_address),
        .m_writedata    (m_writedata),
        .m_write        (m_write),
        .m_read         (m_read),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .m_readdatavalid(m_readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        s_address       = '0;
        s_writedata     = '0;
        s_write         = '0;
        s_read          = '0;
        m_waitrequest   = 1'b0;
        m_readdata      = '0;
        m_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (s_waitrequest !== 4'hF || s_readdatavalid !== 4'h0 ||
            s_readdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_s: wait=%h rdv=%h rdata=%h need F 0 0",
                     s_waitrequest, s_readdatavalid, s_readdata);
        end
        checks++;
        if (m_read !== 1'b0 || m_write !== 1'b0 ||
            m_address !== 32'h0 || m_writedata !== 8'h0) begin
            failures++;
            $display("FAIL reset_m: rd=%b wr=%b a=%h d=%h need 0 0 0 0",
                     m_read, m_write, m_address, m_writedata);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_read_latency();
        do_reset();
        s_read[0] = 1'b1;
        s_address[0 +: AW] = 32'h1000;
        m_waitrequest = 1'b1;
        #1;
        checks++;
        if (m_read !== 1'b0) begin
            failures++;
            $display("FAIL rd_idle_mread: got %b need 0", m_read);
        end
        tick();
        #1;
        checks++;
        if (m_read !== 1'b1 || m_address !== 32'h1000 || s_waitrequest !== 4'hF) begin
            failures++;
            $display("FAIL rd_issue: rd=%b a=%h wait=%h need 1 1000 F",
                     m_read, m_address, s_waitrequest);
        end
        tick();
        #1;
        checks++;
        if (m_read !== 1'b1 || s_waitrequest !== 4'hF) begin
            failures++;
            $display("FAIL rd_stall2: rd=%b wait=%h need 1 F", m_read, s_waitrequest);
        end
        tick();
        m_waitrequest = 1'b0;
        #1;
        checks++;
        if (m_read !== 1'b1 || s_waitrequest !== 4'hF || s_readdatavalid !== 4'h0) begin
            failures++;
            $display("FAIL rd_accept: rd=%b wait=%h rdv=%h need 1 F 0",
                     m_read, s_waitrequest, s_readdatavalid);
        end
        for (int c = 1; c <= 2; c++) begin
            tick();
            #1;
            checks++;
            if (m_read !== 1'b0 || s_waitrequest !== 4'hF || s_readdatavalid !== 4'h0) begin
                failures++;
                $display("FAIL rd_wait%0d: rd=%b wait=%h rdv=%h need 0 F 0",
                         c, m_read, s_waitrequest, s_readdatavalid);
            end
        end
        tick();
        m_readdatavalid = 1'b1;
        m_readdata = 8'hA5;
        #1;
        checks++;
        if (s_waitrequest !== 4'hE || s_readdatavalid !== 4'h1 ||
            s_readdata !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL rd_done: wait=%h rdv=%h rdata=%h need E 1 000000a5",
                     s_waitrequest, s_readdatavalid, s_readdata);
        end
        tick();
        s_read = '0;
        m_readdatavalid = 1'b0;
        #1;
        checks++;
        if (s_readdatavalid !== 4'h0 || m_read !== 1'b0) begin
            failures++;
            $display("FAIL rd_after: rdv=%h rd=%b need 0 0", s_readdatavalid, m_read);
        end
    endtask

    task automatic test_all_write();
        int order[$];
        int low_cnt[NP];
        logic [NP-1:0] done;
        logic [NP-1:0] comp;
        int p;
        do_reset();
        for (int i = 0; i < NP; i++) begin
            s_address[i*AW +: AW]   = 32'h2000 + i;
            s_writedata[i*DW +: DW] = 8'(17 * (i + 1));
            low_cnt[i] = 0;
        end
        s_write = 4'hF;
        done = '0;
        for (int cyc = 0; cyc < 20 && done !== 4'hF; cyc++) begin
            #1;
            if (m_write) begin
                p = int'(m_address[1:0]);
                checks++;
                if (m_writedata !== 8'(17 * (p + 1))) begin
                    failures++;
                    $display("FAIL wr_data_p%0d: got %h need %h",
                             p, m_writedata, 8'(17 * (p + 1)));
                end
            end
            comp = ~s_waitrequest;
            for (int i = 0; i < NP; i++) begin
                if (comp[i]) begin
                    order.push_back(i);
                    low_cnt[i]++;
                end
            end
            done = done | comp;
            tick();
            s_write = s_write & ~comp;
        end
        repeat (3) begin
            #1;
            for (int i = 0; i < NP; i++)
                if (!s_waitrequest[i]) low_cnt[i]++;
            tick();
        end
        checks++;
        if (order.size() != 4) begin
            failures++;
            $display("FAIL wr_count: got %0d need 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] != i) begin
                    failures++;
                    $display("FAIL wr_order%0d: got %0d need %0d", i, order[i], i);
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (low_cnt[i] != 1) begin
                failures++;
                $display("FAIL wr_lowcnt_p%0d: got %0d need 1", i, low_cnt[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_fairness();
        int seq[$];
        int n;
        bit got0;
        do_reset();
        s_address[1*AW +: AW] = 32'h3001;
        s_address[3*AW +: AW] = 32'h3003;
        s_address[0 +: AW]    = 32'h3000;
        s_write[1] = 1'b1;
        s_write[3] = 1'b1;
        for (int cyc = 0; cyc < 30 && seq.size() < 4; cyc++) begin
            #1;
            for (int i = 0; i < NP; i++)
                if (!s_waitrequest[i]) seq.push_back(i);
            tick();
        end
        checks++;
        if (seq.size() != 4) begin
            failures++;
            $display("FAIL rr_count: got %0d need 4", seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seq[i] != ((i % 2 == 0) ? 1 : 3)) begin
                    failures++;
                    $display("FAIL rr_seq%0d: got %0d need %0d",
                             i, seq[i], (i % 2 == 0) ? 1 : 3);
                end
            end
        end
        s_write[0] = 1'b1;
        n = 0;
        got0 = 1'b0;
        for (int cyc = 0; cyc < 30 && !got0; cyc++) begin
            #1;
            if (s_waitrequest !== 4'hF) n++;
            if (!s_waitrequest[0]) got0 = 1'b1;
            tick();
            if (got0) s_write[0] = 1'b0;
        end
        checks++;
        if (!got0 || n > 2) begin
            failures++;
            $display("FAIL rr_port0: served=%b after %0d transfers need 1 within 2",
                     got0, n);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_zero_latency();
        do_reset();
        s_read[1] = 1'b1;
        s_address[1*AW +: AW] = 32'h3101;
        s_write[2] = 1'b1;
        s_address[2*AW +: AW] = 32'h3102;
        s_writedata[2*DW +: DW] = 8'h77;
        m_readdatavalid = 1'b1;
        m_readdata = 8'h5C;
        #1;
        checks++;
        if (s_readdatavalid !== 4'h0 || s_waitrequest !== 4'hF || m_read !== 1'b0) begin
            failures++;
            $display("FAIL zl_idle_stray: rdv=%h wait=%h rd=%b need 0 F 0",
                     s_readdatavalid, s_waitrequest, m_read);
        end
        tick();
        #1;
        checks++;
        if (m_read !== 1'b1 || m_address !== 32'h3101 || s_waitrequest !== 4'hD ||
            s_readdatavalid !== 4'h2 || s_readdata !== 32'h0000_5C00) begin
            failures++;
            $display("FAIL zl_done: rd=%b a=%h wait=%h rdv=%h rdata=%h need 1 3101 D 2 00005c00",
                     m_read, m_address, s_waitrequest, s_readdatavalid, s_readdata);
        end
        tick();
        s_read[1] = 1'b0;
        #1;
        checks++;
        if (s_readdatavalid !== 4'h0 || m_write !== 1'b0 || s_waitrequest !== 4'hF) begin
            failures++;
            $display("FAIL zl_rearb: rdv=%h wr=%b wait=%h need 0 0 F",
                     s_readdatavalid, m_write, s_waitrequest);
        end
        tick();
        #1;
        checks++;
        if (m_write !== 1'b1 || m_address !== 32'h3102 || m_writedata !== 8'h77 ||
            s_waitrequest !== 4'hB || s_readdatavalid !== 4'h0) begin
            failures++;
            $display("FAIL zl_next: wr=%b a=%h d=%h wait=%h rdv=%h need 1 3102 77 B 0",
                     m_write, m_address, m_writedata, s_waitrequest, s_readdatavalid);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_midread();
        do_reset();
        s_read[1] = 1'b1;
        s_address[1*AW +: AW] = 32'h4001;
        tick();
        tick();
        #1;
        checks++;
        if (m_read !== 1'b0 || s_waitrequest !== 4'hF) begin
            failures++;
            $display("FAIL mr_waitrd: rd=%b wait=%h need 0 F", m_read, s_waitrequest);
        end
        reset = 1'b1;
        m_readdatavalid = 1'b1;
        m_readdata = 8'h99;
        s_read = '0;
        s_write = 4'b0101;
        s_address[0 +: AW]    = 32'h4000;
        s_address[2*AW +: AW] = 32'h4002;
        #1;
        checks++;
        if (s_readdatavalid !== 4'h0 || s_waitrequest !== 4'hF) begin
            failures++;
            $display("FAIL mr_async: rdv=%h wait=%h need 0 F",
                     s_readdatavalid, s_waitrequest);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (s_readdatavalid !== 4'h0 || s_waitrequest !== 4'hF || m_write !== 1'b0) begin
            failures++;
            $display("FAIL mr_stray: rdv=%h wait=%h wr=%b need 0 F 0",
                     s_readdatavalid, s_waitrequest, m_write);
        end
        tick();
        m_readdatavalid = 1'b0;
        #1;
        checks++;
        if (m_write !== 1'b1 || m_address !== 32'h4000 || s_waitrequest !== 4'hE) begin
            failures++;
            $display("FAIL mr_first: wr=%b a=%h wait=%h need 1 4000 E",
                     m_write, m_address, s_waitrequest);
        end
        tick();
        s_write[0] = 1'b0;
        tick();
        #1;
        checks++;
        if (m_write !== 1'b1 || m_address !== 32'h4002 || s_waitrequest !== 4'hB) begin
            failures++;
            $display("FAIL mr_second: wr=%b a=%h wait=%h need 1 4002 B",
                     m_write, m_address, s_waitrequest);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_drop_request();
        do_reset();
        s_write[2] = 1'b1;
        s_address[2*AW +: AW] = 32'h5002;
        s_write[3] = 1'b1;
        s_address[3*AW +: AW] = 32'h5003;
        m_waitrequest = 1'b1;
        #1;
        checks++;
        if (m_write !== 1'b0) begin
            failures++;
            $display("FAIL dr_idle: wr=%b need 0", m_write);
        end
        tick();
        #1;
        checks++;
        if (m_write !== 1'b1 || m_address !== 32'h5002 || s_waitrequest !== 4'hF) begin
            failures++;
            $display("FAIL dr_issue: wr=%b a=%h wait=%h need 1 5002 F",
                     m_write, m_address, s_waitrequest);
        end
        tick();
        s_write[2] = 1'b0;
        #1;
        checks++;
        if (m_write !== 1'b0 || s_waitrequest !== 4'hF) begin
            failures++;
            $display("FAIL dr_drop: wr=%b wait=%h need 0 F", m_write, s_waitrequest);
        end
        tick();
        m_waitrequest = 1'b0;
        #1;
        checks++;
        if (m_write !== 1'b0 || s_waitrequest !== 4'hF) begin
            failures++;
            $display("FAIL dr_idle2: wr=%b wait=%h need 0 F", m_write, s_waitrequest);
        end
        tick();
        #1;
        checks++;
        if (m_write !== 1'b1 || m_address !== 32'h5003 || s_waitrequest !== 4'h7) begin
            failures++;
            $display("FAIL dr_next: wr=%b a=%h wait=%h need 1 5003 7",
                     m_write, m_address, s_waitrequest);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_read_latency();
        test_all_write();
        test_fairness();
        test_zero_latency();
        test_reset_midread();
        test_drop_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
